// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder types: receive FSM states, prefix codes, FIFO entry layout.
// No logic; imported by the decoder top.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam int         ENTRY_W      = 10;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word fall-through FIFO, DEPTH a power of two.
// Latency: a push is visible at pop_dat the next cycle; push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can accept a simultaneous push.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: decodes 11-bit frames, folds E0/F0 prefixes into flags, buffers codes.
// Latency: entry and error pulses appear the cycle after the synchronised stop-bit edge; ready low fills the FIFO, then codes drop with overflow.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       extended,
  output logic       released,
  output logic       valid,
  input  logic       ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   ps2_clk_s;
  logic                   ps2_dat_s;
  logic                   fall;

  ps2_state_t state_q, state_d;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             par_q;
  logic [CNT_W-1:0] idle_cnt;
  logic             ext_q;
  logic             rel_q;

  logic   frame_done;
  logic   timeout;
  logic   parity_ok;
  logic   good;
  logic   push;
  logic   pop;
  logic   fifo_full;
  logic   fifo_empty;
  entry_t push_entry;
  entry_t head;
  logic [ENTRY_W-1:0] head_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= ps2_clk_s;
    end
  end

  assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync[SYNC_STAGES-1];
  assign fall      = clk_prev && !ps2_clk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    timeout    = 1'b0;
    if (state_q != IDLE && !fall && idle_cnt == CNT_LAST) begin
      timeout = 1'b1;
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:   if (!ps2_dat_s) state_d = DATA;
        DATA:   if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stop-bit value is the synchronised data seen on the closing edge.
  assign parity_ok = ^{shift_q, par_q};
  assign good      = frame_done && parity_ok && ps2_dat_s;
  assign push      = good && (shift_q != PS2_EXT_CODE) && (shift_q != PS2_BRK_CODE);
  assign pop       = valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (fall) begin
        case (state_q)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift_q <= {ps2_dat_s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_q <= ps2_dat_s;
          default: ;
        endcase
      end
      if (fall || state_q == IDLE) idle_cnt <= '0;
      else                         idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else if (timeout || (frame_done && !good)) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else if (good) begin
      if (shift_q == PS2_EXT_CODE) begin
        ext_q <= 1'b1;
      end else if (shift_q == PS2_BRK_CODE) begin
        rel_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end
    end
  end

  // A parity failure masks a simultaneous stop-bit failure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= frame_done && !parity_ok;
      frame_err  <= timeout || (frame_done && parity_ok && !ps2_dat_s);
      overflow   <= push && fifo_full && !pop;
    end
  end

  assign push_entry = '{ext: ext_q, rel: rel_q, code: shift_q};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head     = entry_t'(head_dat);
  assign valid    = !fifo_empty;
  assign key      = valid ? head.code : 8'h00;
  assign extended = valid && head.ext;
  assign released = valid && head.rel;

endmodule
